// File: rtl/pa_clic_arb.sv
// pa_clic_arb: CLIC interrupt arbiter ahead of the RTU interrupt-judge stage.
// Define PA_CLIC_ARB_EDGE_TRIG_EN to enable per-source edge triggering.
module pa_clic_arb #(
   parameter int INT_NUM = 16
) (
   input  logic               forever_cpuclk,
   input  logic               cpurst_b,
   input  logic [INT_NUM-1:0] pad_clic_int_src,
   input  logic               cfg_wen,
   input  logic [5:0]         cfg_idx,
   input  logic [1:0]         cfg_field,
   input  logic [7:0]         cfg_wdata,
   output logic [7:0]         cfg_rdata,
   input  logic [11:0]        cpu_clic_curid,
   input  logic               cpu_clic_int_exit,
   output logic [11:0]        clic_cpu_int_id,
   output logic [7:0]         clic_cpu_int_il,
   output logic [1:0]         clic_cpu_int_priv,
   output logic               clic_cpu_int_hv
);

   typedef enum logic {ARB, HOLD} state_t;

   state_t state, state_nxt;

   logic [INT_NUM-1:0]      ie;
   logic [INT_NUM-1:0]      ip;
   logic [INT_NUM-1:0]      ip_nxt;
   logic [INT_NUM-1:0]      hv;
   logic [INT_NUM-1:0]      trig;
   logic [INT_NUM-1:0][7:0] ctl;
   logic [INT_NUM-1:0]      sel;

   logic [11:0] best_id;
   logic [7:0]  best_il;
   logic        best_hv;

   logic [11:0] id_nxt;
   logic [7:0]  il_nxt;
   logic [1:0]  priv_nxt;
   logic        hv_nxt;

   always_comb begin
      for (int k = 0; k < INT_NUM; k++) begin
         sel[k] = (cfg_idx == 6'(k));
      end
   end

`ifdef PA_CLIC_ARB_EDGE_TRIG_EN
   logic [INT_NUM-1:0] src_f;

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         src_f <= '0;
         trig  <= '0;
      end else begin
         src_f <= pad_clic_int_src;
         for (int k = 0; k < INT_NUM; k++) begin
            if (cfg_wen && sel[k] && cfg_field == 2'd1) begin
               trig[k] <= cfg_wdata[0];
            end
         end
      end
   end

   // cfg write beats a new edge, which beats the exit clear
   always_comb begin
      for (int k = 0; k < INT_NUM; k++) begin
         ip_nxt[k] = pad_clic_int_src[k];
         if (trig[k]) begin
            ip_nxt[k] = ip[k];
            if (cpu_clic_int_exit && cpu_clic_curid == 12'(k)) begin
               ip_nxt[k] = 1'b0;
            end
            if (pad_clic_int_src[k] && !src_f[k]) begin
               ip_nxt[k] = 1'b1;
            end
            if (cfg_wen && sel[k] && cfg_field == 2'd3) begin
               ip_nxt[k] = cfg_wdata[0];
            end
         end
      end
   end
`else
   logic unused_curid;

   assign unused_curid = ^cpu_clic_curid;
   assign trig         = '0;

   always_comb begin
      ip_nxt = pad_clic_int_src;
   end
`endif

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         ie  <= '0;
         ip  <= '0;
         hv  <= '0;
         ctl <= '0;
      end else begin
         ip <= ip_nxt;
         for (int k = 0; k < INT_NUM; k++) begin
            if (cfg_wen && sel[k]) begin
               unique case (cfg_field)
                  2'd0:    ie[k]  <= cfg_wdata[0];
                  2'd1:    hv[k]  <= cfg_wdata[1];
                  2'd2:    ctl[k] <= cfg_wdata;
                  default: ;
               endcase
            end
         end
      end
   end

   always_comb begin
      cfg_rdata = '0;
      for (int k = 0; k < INT_NUM; k++) begin
         if (sel[k]) begin
            unique case (cfg_field)
               2'd0:    cfg_rdata = {7'd0, ie[k]};
               2'd1:    cfg_rdata = {6'd0, hv[k], trig[k]};
               2'd2:    cfg_rdata = ctl[k];
               default: cfg_rdata = {7'd0, ip[k]};
            endcase
         end
      end
   end

   // ascending scan with >= lets the higher id win a ctl tie
   always_comb begin
      best_id = '0;
      best_il = '0;
      best_hv = 1'b0;
      for (int k = 0; k < INT_NUM; k++) begin
         if (ip[k] && ie[k] && ctl[k] != 8'd0
             && ctl[k] >= best_il) begin
            best_id = 12'(k);
            best_il = ctl[k];
            best_hv = hv[k];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      id_nxt    = best_id;
      il_nxt    = best_il;
      priv_nxt  = (best_il != 8'd0) ? 2'b11 : 2'b00;
      hv_nxt    = best_hv;
      unique case (state)
         ARB: begin
            if (cpu_clic_int_exit) begin
               state_nxt = HOLD;
               id_nxt    = '0;
               il_nxt    = '0;
               priv_nxt  = '0;
               hv_nxt    = 1'b0;
            end
         end
         HOLD: begin
            if (cpu_clic_int_exit) begin
               id_nxt   = '0;
               il_nxt   = '0;
               priv_nxt = '0;
               hv_nxt   = 1'b0;
            end else begin
               state_nxt = ARB;
            end
         end
         default: state_nxt = ARB;
      endcase
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state             <= ARB;
         clic_cpu_int_id   <= '0;
         clic_cpu_int_il   <= '0;
         clic_cpu_int_priv <= '0;
         clic_cpu_int_hv   <= 1'b0;
      end else begin
         state             <= state_nxt;
         clic_cpu_int_id   <= id_nxt;
         clic_cpu_int_il   <= il_nxt;
         clic_cpu_int_priv <= priv_nxt;
         clic_cpu_int_hv   <= hv_nxt;
      end
   end

endmodule
